// File: rtl/nn_mem_responder.sv
// Memory-side responder for the compute engine's W and X 1-bit request ports.
// After reset, every X bank is swept to zero before either port accepts traffic.
module nn_mem_responder #(
  parameter int W_ADDR_LEN = 20,
  parameter int W_DEPTH    = 802816,
  parameter int W_SEL_LEN  = 2,
  parameter int X_ADDR_LEN = 10,
  parameter int X_DEPTH    = 1024,
  parameter int X_SEL_LEN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W_ADDR_LEN-1:0] w_addr,
  input  logic [W_SEL_LEN-1:0]  w_sel,
  input  logic                  w_rq,
  input  logic                  w_wq,
  input  logic                  w_wdata,
  output logic                  w_rdata,
  output logic                  w_rvalid,
  output logic                  w_err,
  input  logic [X_ADDR_LEN-1:0] x_addr,
  input  logic [X_SEL_LEN-1:0]  x_sel,
  input  logic                  x_rq,
  input  logic                  x_wq,
  input  logic                  x_wdata,
  output logic                  x_rdata,
  output logic                  x_rvalid,
  output logic                  x_err,
  output logic                  ready,
  output logic [7:0]            err_cnt
);

  localparam int W_BANKS = 1 << W_SEL_LEN;
  localparam int X_BANKS = 1 << X_SEL_LEN;
  localparam logic [W_ADDR_LEN:0] W_LIMIT = (W_ADDR_LEN + 1)'(W_DEPTH);
  localparam logic [X_ADDR_LEN:0] X_LIMIT = (X_ADDR_LEN + 1)'(X_DEPTH);

  typedef enum logic {INIT, READY} state_t;

  state_t                state, state_next;
  logic [X_ADDR_LEN-1:0] init_ptr;
  logic                  sweeping, in_ready, sweep_last;

  // Banks are sized to the full address space so the index width matches
  // exactly; entries at or above DEPTH are never reached.
  logic w_mem [0:W_BANKS-1][0:(1 << W_ADDR_LEN)-1];
  logic x_mem [0:X_BANKS-1][0:(1 << X_ADDR_LEN)-1];

  logic w_in_range, w_rd, w_wr, w_bad;
  logic x_in_range, x_rd, x_wr, x_bad;
  logic w_err_next, x_err_next;
  logic [8:0] cnt_sum;

  assign sweep_last = (init_ptr == X_ADDR_LEN'(X_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_next;
      if (sweeping) init_ptr <= init_ptr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && sweep_last) state_next = READY;
  end

  always_comb begin
    sweeping = (state == INIT);
    in_ready = (state == READY);
    ready    = in_ready;
  end

  always_comb begin
    w_in_range = ({1'b0, w_addr} < W_LIMIT);
    w_rd       = w_rq & ~w_wq & w_in_range;
    w_wr       = w_wq & ~w_rq & w_in_range;
    w_bad      = (w_rq & w_wq) | ((w_rq | w_wq) & ~w_in_range);
    x_in_range = ({1'b0, x_addr} < X_LIMIT);
    x_rd       = x_rq & ~x_wq & x_in_range;
    x_wr       = x_wq & ~x_rq & x_in_range;
    x_bad      = (x_rq & x_wq) | ((x_rq | x_wq) & ~x_in_range);
    w_err_next = in_ready & w_bad;
    x_err_next = in_ready & x_bad;
    cnt_sum    = {1'b0, err_cnt} + 9'(w_err_next) + 9'(x_err_next);
  end

  always_ff @(posedge clk) begin
    if (!rst && in_ready && w_wr) w_mem[w_sel][w_addr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweeping) begin
        for (int unsigned b = 0; b < X_BANKS; b++) x_mem[b][init_ptr] <= 1'b0;
      end else if (x_wr) begin
        x_mem[x_sel][x_addr] <= x_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_rdata  <= 1'b0;
      w_rvalid <= 1'b0;
      w_err    <= 1'b0;
    end else begin
      w_rvalid <= in_ready & w_rd;
      w_err    <= w_err_next;
      if (in_ready && w_rd)                          w_rdata <= w_mem[w_sel][w_addr];
      else if (in_ready && (w_rq | w_wq) && !w_in_range) w_rdata <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_rdata  <= 1'b0;
      x_rvalid <= 1'b0;
      x_err    <= 1'b0;
    end else begin
      x_rvalid <= in_ready & x_rd;
      x_err    <= x_err_next;
      if (in_ready && x_rd)                          x_rdata <= x_mem[x_sel][x_addr];
      else if (in_ready && (x_rq | x_wq) && !x_in_range) x_rdata <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else     err_cnt <= cnt_sum[8] ? '1 : cnt_sum[7:0];
  end

endmodule

// File: tb/tb_nn_mem_responder.sv
// Scoreboard bench for nn_mem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares them as the DUT pulses rvalid/err.
module tb_nn_mem_responder;

  localparam int WA = 7;
  localparam int WD = 64;
  localparam int WS = 2;
  localparam int XA = 5;
  localparam int XD = 16;
  localparam int XS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [WA-1:0] w_addr;
  logic [WS-1:0] w_sel;
  logic          w_rq, w_wq, w_wdata, w_rdata, w_rvalid, w_err;
  logic [XA-1:0] x_addr;
  logic [XS-1:0] x_sel;
  logic          x_rq, x_wq, x_wdata, x_rdata, x_rvalid, x_err;
  logic          ready;
  logic [7:0]    err_cnt;

  nn_mem_responder #(
    .W_ADDR_LEN(WA), .W_DEPTH(WD), .W_SEL_LEN(WS),
    .X_ADDR_LEN(XA), .X_DEPTH(XD), .X_SEL_LEN(XS)
  ) dut (
    .clk(clk), .rst(rst),
    .w_addr(w_addr), .w_sel(w_sel), .w_rq(w_rq), .w_wq(w_wq), .w_wdata(w_wdata),
    .w_rdata(w_rdata), .w_rvalid(w_rvalid), .w_err(w_err),
    .x_addr(x_addr), .x_sel(x_sel), .x_rq(x_rq), .x_wq(x_wq), .x_wdata(x_wdata),
    .x_rdata(x_rdata), .x_rvalid(x_rvalid), .x_err(x_err),
    .ready(ready), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   due;
    logic is_err;
    logic chk_data;
    logic data;
  } exp_t;

  exp_t qw[$];
  exp_t qx[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int p, input logic rv, input logic er, input logic rd);
    exp_t  e;
    int    sz;
    string nm;
    nm = (p == 0) ? "w" : "x";
    sz = (p == 0) ? qw.size() : qx.size();
    if (rv || er) begin
      n_cmp++;
      if (sz == 0) begin
        n_bad++;
        $display("FAIL %s_unexpected: rvalid=%0b err=%0b rdata=%0b at cycle %0d, no response expected",
                 nm, rv, er, rd, cyc);
      end else begin
        if (p == 0) e = qw.pop_front();
        else        e = qx.pop_front();
        if (e.due != cyc || e.is_err != er || rv == er || (e.chk_data && rd !== e.data)) begin
          n_bad++;
          $display("FAIL %s_resp: got rvalid=%0b err=%0b rdata=%0b at cycle %0d, expected err=%0b data=%0b at cycle %0d",
                   nm, rv, er, rd, cyc, e.is_err, e.data, e.due);
        end
      end
    end else if (sz != 0) begin
      if (p == 0) e = qw[0];
      else        e = qx[0];
      if (e.due <= cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_missing: no pulse at cycle %0d, expected err=%0b data=%0b", nm, cyc, e.is_err, e.data);
        if (p == 0) void'(qw.pop_front());
        else        void'(qx.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, w_rvalid, w_err, w_rdata);
    mon(1, x_rvalid, x_err, x_rdata);
  end

  task automatic tick();
    @(negedge clk);
    w_rq = 1'b0; w_wq = 1'b0;
    x_rq = 1'b0; x_wq = 1'b0;
  endtask

  task automatic set_w(input logic rq, input logic wq, input int sel, input int addr, input logic wd);
    w_rq = rq; w_wq = wq; w_sel = WS'(sel); w_addr = WA'(addr); w_wdata = wd;
  endtask

  task automatic set_x(input logic rq, input logic wq, input int sel, input int addr, input logic wd);
    x_rq = rq; x_wq = wq; x_sel = XS'(sel); x_addr = XA'(addr); x_wdata = wd;
  endtask

  task automatic exp_w(input logic is_err, input logic chk_data, input logic data);
    exp_t e;
    e.due = cyc + 1; e.is_err = is_err; e.chk_data = chk_data; e.data = data;
    qw.push_back(e);
  endtask

  task automatic exp_x(input logic is_err, input logic chk_data, input logic data);
    exp_t e;
    e.due = cyc + 1; e.is_err = is_err; e.chk_data = chk_data; e.data = data;
    qx.push_back(e);
  endtask

  task automatic w_read(input int sel, input int addr, input logic d);
    set_w(1'b1, 1'b0, sel, addr, 1'b0); exp_w(1'b0, 1'b1, d); tick();
  endtask

  task automatic x_read(input int sel, input int addr, input logic d);
    set_x(1'b1, 1'b0, sel, addr, 1'b0); exp_x(1'b0, 1'b1, d); tick();
  endtask

  // Checks ready stays low for exactly XD cycles after reset release; with
  // busy set, drives requests that must be ignored during the sweep.
  task automatic wait_ready(input bit busy);
    for (int i = 0; i < XD; i++) begin
      chk("ready_low", int'(ready), 0);
      if (busy) begin
        if (i % 2 == 0) begin
          set_x(1'b0, 1'b1, 0, 7, 1'b1);
          set_w(1'b0, 1'b1, 2, 5, 1'b0);
        end else begin
          set_x(1'b1, 1'b0, 0, 7, 1'b0);
          set_w(1'b1, 1'b0, 0, WD, 1'b0);
        end
      end
      tick();
      chk("init_quiet", int'({w_rvalid, w_err, x_rvalid, x_err}), 0);
    end
    chk("ready_high", int'(ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_w(1'b0, 1'b0, 0, 0, 1'b0);
    set_x(1'b0, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_ready", int'(ready), 0);
    chk("reset_errcnt", int'(err_cnt), 0);
    chk("reset_pulses", int'({w_rvalid, w_err, x_rvalid, x_err}), 0);
    chk("reset_rdata", int'({w_rdata, x_rdata}), 0);

    // Sweep timing and all X entries cleared
    rst = 1'b0;
    wait_ready(1'b0);
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < XD; a++) x_read(s, a, 1'b0);

    // W write then read-back, separate banks
    set_w(1'b0, 1'b1, 2, 5, 1'b1); tick();
    w_read(2, 5, 1'b1);
    set_w(1'b0, 1'b1, 1, 5, 1'b0); tick();
    w_read(1, 5, 1'b0);

    // Read+write conflict on X
    set_x(1'b1, 1'b1, 0, 3, 1'b1); exp_x(1'b1, 1'b0, 1'b0); tick();
    chk("errcnt_conflict", int'(err_cnt), 1);
    x_read(0, 3, 1'b0);
    chk("errcnt_hold", int'(err_cnt), 1);

    // Out-of-range on both ports in the same cycle; rdata was 1 beforehand
    set_x(1'b0, 1'b1, 1, 9, 1'b1); tick();
    x_read(1, 9, 1'b1);
    w_read(2, 5, 1'b1);
    set_x(1'b1, 1'b0, 0, XD, 1'b0); exp_x(1'b1, 1'b1, 1'b0);
    set_w(1'b1, 1'b0, 0, WD, 1'b0); exp_w(1'b1, 1'b1, 1'b0);
    tick();
    chk("errcnt_dual", int'(err_cnt), 3);

    // Reset mid-operation: X re-swept, W retained, INIT requests ignored
    set_x(1'b0, 1'b1, 0, 7, 1'b1); tick();
    x_read(0, 7, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rerst_errcnt", int'(err_cnt), 0);
    wait_ready(1'b1);
    x_read(0, 7, 1'b0);
    w_read(2, 5, 1'b1);
    chk("errcnt_after_init", int'(err_cnt), 0);

    // Saturation, including a +2 step from 254
    for (int i = 0; i < 127; i++) begin
      set_x(1'b1, 1'b1, 0, 0, 1'b0); exp_x(1'b1, 1'b0, 1'b0);
      set_w(1'b1, 1'b0, 0, WD, 1'b0); exp_w(1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("errcnt_254", int'(err_cnt), 254);
    set_x(1'b1, 1'b1, 0, 0, 1'b0); exp_x(1'b1, 1'b0, 1'b0);
    set_w(1'b1, 1'b0, 0, WD, 1'b0); exp_w(1'b1, 1'b1, 1'b0);
    tick();
    chk("errcnt_sat", int'(err_cnt), 255);
    for (int i = 0; i < 170; i++) begin
      set_x(1'b1, 1'b0, 2, XD + 3, 1'b0); exp_x(1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("errcnt_stays", int'(err_cnt), 255);

    repeat (3) tick();
    chk("w_queue_drained", qw.size(), 0);
    chk("x_queue_drained", qx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
